// File: rtl/lcd_frame_driver_pkg.sv
// Shared definitions for the HD44780 frame driver: LCD command bytes,
// blank character, refresh state and strobe phase encodings.
package lcd_defs;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE0    = 8'h80;
    localparam logic [7:0] CMD_LINE1    = 8'hC0;
    localparam logic [7:0] BLANK_CHAR   = 8'h20;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_CLEAR_WAIT,
        ST_LINE_CMD,
        ST_CHARS
    } refresh_state_t;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C
    } phase_t;

    // Power-up command list, sent in index order
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_driver_if.sv
// Upstream byte stream plus the LCD pin bundle of the frame driver.
// master = stream source / panel side, slave = lcd_frame_driver.
interface lcd_frame_driver_if;

    logic [3:0] MODE;
    logic       RW_IN;
    logic       RS_IN;
    logic [7:0] DATA_IN;

    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic       INIT_DONE;

    modport master (
        output MODE, RW_IN, RS_IN, DATA_IN,
        input  LCD_E, LCD_RS, LCD_RW, LCD_DATA, INIT_DONE
    );

    modport slave (
        input  MODE, RW_IN, RS_IN, DATA_IN,
        output LCD_E, LCD_RS, LCD_RW, LCD_DATA, INIT_DONE
    );

endinterface

// File: rtl/lcd_frame_buf.sv
// 2x16 character shadow buffer with capture pointer. Characters past
// column 15 are dropped until a new set-address command arrives.
module lcd_frame_buf
    import lcd_defs::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       wr_en,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       rd_line,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_data
);

    logic [7:0] mem [2][16];
    logic       ptr_line;
    logic [3:0] ptr_col;
    logic       ptr_valid;

    // Clear outranks any capture in the same cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int l = 0; l < 2; l++)
                for (int c = 0; c < 16; c++)
                    mem[l][c] <= BLANK_CHAR;
            ptr_line  <= 1'b0;
            ptr_col   <= 4'd0;
            ptr_valid <= 1'b1;
        end else if (clear) begin
            for (int l = 0; l < 2; l++)
                for (int c = 0; c < 16; c++)
                    mem[l][c] <= BLANK_CHAR;
            ptr_valid <= 1'b0;
        end else if (wr_en) begin
            if (!wr_rs) begin
                if (wr_data[7]) begin
                    ptr_line  <= wr_data[6];
                    ptr_col   <= wr_data[3:0];
                    ptr_valid <= 1'b1;
                end
            end else if (ptr_valid) begin
                mem[ptr_line][ptr_col] <= wr_data;
                if (ptr_col == 4'd15)
                    ptr_valid <= 1'b0;
                else
                    ptr_col <= ptr_col + 4'd1;
            end
        end
    end

    // Pre-edge contents, so a same-cycle write is not visible to the reader
    assign rd_data = mem[rd_line][rd_col];

endmodule

// File: rtl/lcd_frame_driver.sv
// Captures the mode byte stream into a shadow frame and refreshes a 2x16
// HD44780 panel from it. Define LCD_FRAME_CLEAR_EN to blank the frame on MODE change.
module lcd_frame_driver
    import lcd_defs::*;
#(
    parameter int INIT_WAIT  = 40,
    parameter int CLEAR_WAIT = 2
) (
    input logic               CLK,
    input logic               RESET,
    lcd_frame_driver_if.slave bus
);

    refresh_state_t state, state_nxt;
    phase_t         phase, phase_nxt;
    logic [15:0]    cnt, cnt_nxt;
    logic [1:0]     cmd_idx, cmd_idx_nxt;
    logic [3:0]     col, col_nxt;
    logic           line, line_nxt;

    logic           lcd_e, lcd_rs, init_done;
    logic [7:0]     lcd_data;
    logic           e_nxt, rs_nxt, done_nxt;
    logic [7:0]     data_nxt;

    logic           frame_clear;
    logic [7:0]     rd_data;

`ifdef LCD_FRAME_CLEAR_EN
    logic [3:0] mode_q;
    logic       mode_valid;

    // First cycle after reset only loads the reference copy of MODE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mode_q     <= 4'd0;
            mode_valid <= 1'b0;
        end else begin
            mode_q     <= bus.MODE;
            mode_valid <= 1'b1;
        end
    end

    assign frame_clear = mode_valid && (bus.MODE != mode_q);
`else
    logic unused_mode;
    assign unused_mode = ^bus.MODE;
    assign frame_clear = 1'b0;
`endif

    lcd_frame_buf u_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (frame_clear),
        .wr_en   (~bus.RW_IN),
        .wr_rs   (bus.RS_IN),
        .wr_data (bus.DATA_IN),
        .rd_line (line),
        .rd_col  (col),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_POWER_WAIT;
            phase     <= PH_A;
            cnt       <= 16'd0;
            cmd_idx   <= 2'd0;
            col       <= 4'd0;
            line      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            cmd_idx   <= cmd_idx_nxt;
            col       <= col_nxt;
            line      <= line_nxt;
            lcd_e     <= e_nxt;
            lcd_rs    <= rs_nxt;
            lcd_data  <= data_nxt;
            init_done <= done_nxt;
        end
    end

    // Wait states count cycles; strobing states advance once per A-B-C triple
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        cnt_nxt     = cnt;
        cmd_idx_nxt = cmd_idx;
        col_nxt     = col;
        line_nxt    = line;
        case (state)
            ST_POWER_WAIT: begin
                if (cnt == 16'(INIT_WAIT - 1)) begin
                    state_nxt   = ST_INIT;
                    cnt_nxt     = 16'd0;
                    phase_nxt   = PH_A;
                    cmd_idx_nxt = 2'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_CLEAR_WAIT: begin
                if (cnt == 16'(CLEAR_WAIT - 1)) begin
                    state_nxt = ST_LINE_CMD;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                case (phase)
                    PH_A: phase_nxt = PH_B;
                    PH_B: phase_nxt = PH_C;
                    default: begin
                        phase_nxt = PH_A;
                        case (state)
                            ST_INIT: begin
                                if (cmd_idx == 2'd3) begin
                                    state_nxt = (CLEAR_WAIT == 0) ? ST_LINE_CMD : ST_CLEAR_WAIT;
                                    cnt_nxt   = 16'd0;
                                end else begin
                                    cmd_idx_nxt = cmd_idx + 2'd1;
                                end
                            end
                            ST_LINE_CMD: begin
                                state_nxt = ST_CHARS;
                                col_nxt   = 4'd0;
                            end
                            default: begin
                                if (col == 4'd15) begin
                                    state_nxt = ST_LINE_CMD;
                                    line_nxt  = ~line;
                                end else begin
                                    col_nxt = col + 4'd1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // RS/DATA load only in phase A and hold otherwise; E is high only in phase B
    always_comb begin
        e_nxt    = 1'b0;
        rs_nxt   = lcd_rs;
        data_nxt = lcd_data;
        done_nxt = (state == ST_LINE_CMD) || (state == ST_CHARS);
        if (state == ST_INIT || state == ST_LINE_CMD || state == ST_CHARS) begin
            case (phase)
                PH_A: begin
                    rs_nxt = (state == ST_CHARS);
                    case (state)
                        ST_INIT:     data_nxt = init_cmd(cmd_idx);
                        ST_LINE_CMD: data_nxt = line ? CMD_LINE1 : CMD_LINE0;
                        default:     data_nxt = rd_data;
                    endcase
                end
                PH_B:    e_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.LCD_E     = lcd_e;
    assign bus.LCD_RS    = lcd_rs;
    assign bus.LCD_RW    = 1'b0;
    assign bus.LCD_DATA  = lcd_data;
    assign bus.INIT_DONE = init_done;

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Directed bench for lcd_frame_driver: init timing table, frame contents
// after streamed writes, overflow, idle stream, MODE clear and mid-strobe reset.
module tb_lcd_frame_driver;

    logic CLK;
    logic RESET;

    lcd_frame_driver_if bus ();

    lcd_frame_driver #(
        .INIT_WAIT  (40),
        .CLEAR_WAIT (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic       e;
        logic       rs;
        logic [7:0] data;
        logic       done;
    } init_vec_t;

    init_vec_t  init_tab [17];
    logic [7:0] model [2][16];
    int         vec_count;
    int         miscompares;

    task automatic checkOutput(input string name, input logic e, input logic rs,
                               input logic [7:0] data, input logic done);
        vec_count++;
        if (bus.LCD_E !== e || bus.LCD_RS !== rs || bus.LCD_RW !== 1'b0 ||
            bus.LCD_DATA !== data || bus.INIT_DONE !== done) begin
            miscompares++;
            $display("[TB] FAIL %s: got E=%b RS=%b RW=%b DATA=%h DONE=%b, expected E=%b RS=%b RW=0 DATA=%h DONE=%b",
                     name, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA, bus.INIT_DONE,
                     e, rs, data, done);
        end
    endtask

    // One upstream write held across exactly one rising edge
    task automatic applyStimulus(input logic rs, input logic [7:0] data);
        @(negedge CLK);
        bus.RW_IN   = 1'b0;
        bus.RS_IN   = rs;
        bus.DATA_IN = data;
        @(negedge CLK);
        bus.RW_IN   = 1'b1;
    endtask

    task automatic model_blank();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 16; c++)
                model[l][c] = 8'h20;
    endtask

    // Must be entered just after RESET rises, before edge 0
    task automatic run_init_table(input string tag);
        int cur;
        cur = -1;
        for (int i = 0; i < 17; i++) begin
            repeat (init_tab[i].cyc - cur) @(posedge CLK);
            #1;
            cur = init_tab[i].cyc;
            checkOutput($sformatf("%s cycle %0d", tag, init_tab[i].cyc),
                        init_tab[i].e, init_tab[i].rs, init_tab[i].data, init_tab[i].done);
        end
    endtask

    task automatic get_byte(output logic rs, output logic [7:0] data, output bit ok);
        ok   = 1'b0;
        rs   = 1'b0;
        data = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            #1;
            if (bus.LCD_E === 1'b1) begin
                rs   = bus.LCD_RS;
                data = bus.LCD_DATA;
                ok   = 1'b1;
                return;
            end
        end
    endtask

    // Waits for the next refresh of a line and compares its 16 characters
    task automatic check_line(input int ln);
        logic       rs;
        logic [7:0] data;
        logic [7:0] cmd;
        bit         ok;
        bit         found;
        cmd   = (ln == 0) ? 8'h80 : 8'hC0;
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            get_byte(rs, data, ok);
            if (!ok) break;
            if (rs == 1'b0 && data == cmd) found = 1'b1;
        end
        if (!found) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL line%0d command: got no %h strobe, required one within budget", ln, cmd);
            return;
        end
        for (int c = 0; c < 16; c++) begin
            get_byte(rs, data, ok);
            vec_count++;
            if (!ok || rs !== 1'b1 || data !== model[ln][c]) begin
                miscompares++;
                $display("[TB] FAIL line%0d col%0d: got RS=%b DATA=%h strobe=%0d, expected RS=1 DATA=%h",
                         ln, c, rs, data, ok, model[ln][c]);
            end
        end
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        RESET       = 1'b0;
        bus.MODE    = 4'b0111;
        bus.RW_IN   = 1'b1;
        bus.RS_IN   = 1'b0;
        bus.DATA_IN = 8'h00;
        model_blank();

        init_tab[0]  = '{39, 1'b0, 1'b0, 8'h00, 1'b0};
        init_tab[1]  = '{40, 1'b0, 1'b0, 8'h38, 1'b0};
        init_tab[2]  = '{41, 1'b1, 1'b0, 8'h38, 1'b0};
        init_tab[3]  = '{42, 1'b0, 1'b0, 8'h38, 1'b0};
        init_tab[4]  = '{43, 1'b0, 1'b0, 8'h0C, 1'b0};
        init_tab[5]  = '{44, 1'b1, 1'b0, 8'h0C, 1'b0};
        init_tab[6]  = '{45, 1'b0, 1'b0, 8'h0C, 1'b0};
        init_tab[7]  = '{46, 1'b0, 1'b0, 8'h06, 1'b0};
        init_tab[8]  = '{47, 1'b1, 1'b0, 8'h06, 1'b0};
        init_tab[9]  = '{48, 1'b0, 1'b0, 8'h06, 1'b0};
        init_tab[10] = '{49, 1'b0, 1'b0, 8'h01, 1'b0};
        init_tab[11] = '{50, 1'b1, 1'b0, 8'h01, 1'b0};
        init_tab[12] = '{51, 1'b0, 1'b0, 8'h01, 1'b0};
        init_tab[13] = '{52, 1'b0, 1'b0, 8'h01, 1'b0};
        init_tab[14] = '{53, 1'b0, 1'b0, 8'h01, 1'b0};
        init_tab[15] = '{54, 1'b0, 1'b0, 8'h80, 1'b1};
        init_tab[16] = '{55, 1'b1, 1'b0, 8'h80, 1'b1};

        #12;
        checkOutput("reset values", 1'b0, 1'b0, 8'h00, 1'b0);

        @(negedge CLK);
        RESET = 1'b1;
        run_init_table("init");

        // Idle stream with a harmless-looking byte on the bus
        bus.DATA_IN = 8'h02;
        repeat (200) @(posedge CLK);
        check_line(0);
        check_line(1);

        applyStimulus(1'b0, 8'h80);
        applyStimulus(1'b1, 8'h41);
        applyStimulus(1'b1, 8'h42);
        model[0][0] = 8'h41;
        model[0][1] = 8'h42;
        check_line(0);

        // Column 15 write closes the pointer; 'Z' must not land anywhere
        applyStimulus(1'b0, 8'h8F);
        applyStimulus(1'b1, 8'h59);
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b0, 8'hC5);
        applyStimulus(1'b1, 8'h58);
        model[0][15] = 8'h59;
        model[1][5]  = 8'h58;
        check_line(0);
        check_line(1);

        applyStimulus(1'b0, 8'h80);
        applyStimulus(1'b1, 8'h51);
        model[0][0] = 8'h51;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        bus.MODE = 4'b0000;
`ifdef LCD_FRAME_CLEAR_EN
        model_blank();
`endif
        repeat (3) @(posedge CLK);
        check_line(0);
        check_line(1);

        begin : mid_strobe_reset
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge CLK);
                #1;
                if (bus.LCD_E === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                vec_count++;
                miscompares++;
                $display("[TB] FAIL phase B search: got no E pulse in 10 cycles, required one");
            end
            #2 RESET = 1'b0;
            #1 checkOutput("reset mid strobe", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        model_blank();
        @(negedge CLK);
        RESET = 1'b1;
        run_init_table("reinit");
        check_line(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
